// File: rtl/any1_pkg.sv
// any1_pkg -- shared types for the any1 memory request unit.
//
// Holds the access-size encoding, the fault codes reported with done,
// the memory request state machine encoding, and the load-extension
// helper used when a load finishes.
package any1_pkg;

    // Access size as carried on the sz input.
    typedef enum logic [1:0] {
        SZ_BYTE  = 2'd0,
        SZ_WYDE  = 2'd1,
        SZ_TETRA = 2'd2,
        SZ_OCTA  = 2'd3
    } sz_e;

    // Completion status reported alongside done.
    typedef enum logic [1:0] {
        FLT_OK  = 2'd0,
        FLT_BUS = 2'd1,
        FLT_TMO = 2'd2
    } fault_e;

    // Request sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC1 = 2'd1,
        ACC2 = 2'd2,
        FIN  = 2'd3
    } state_e;

    // Keep the low bytes of a right-justified load and zero- or
    // sign-extend from the top bit of the accessed size.
    function automatic logic [63:0] load_ext(input logic [63:0] d,
                                             input sz_e         s,
                                             input logic        sgn);
        logic [63:0] r;
        case (s)
            SZ_BYTE:  r = {{56{sgn & d[7]}},  d[7:0]};
            SZ_WYDE:  r = {{48{sgn & d[15]}}, d[15:0]};
            SZ_TETRA: r = {{32{sgn & d[31]}}, d[31:0]};
            default:  r = d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/any1_memreq_if.sv
// any1_memreq_if -- 64-bit memory bus between the request unit and memory.
//
// Signals:
//   cyc_o, stb_o, we_o  bus cycle, strobe, write enable   (master -> slave)
//   sel_o[7:0]          byte lane selects                 (master -> slave)
//   adr_o[AWID-1:0]     octa-aligned bus address          (master -> slave)
//   dat_o[63:0]         write data                        (master -> slave)
//   ack_i, err_i        acknowledge, bus error            (slave -> master)
//   dat_i[63:0]         read data                         (slave -> master)
interface any1_memreq_if #(
    parameter int AWID = 32
) ();

    logic            cyc_o;
    logic            stb_o;
    logic            we_o;
    logic [7:0]      sel_o;
    logic [AWID-1:0] adr_o;
    logic [63:0]     dat_o;
    logic            ack_i;
    logic            err_i;
    logic [63:0]     dat_i;

    modport master (
        output cyc_o, stb_o, we_o, sel_o, adr_o, dat_o,
        input  ack_i, err_i, dat_i
    );

    modport slave (
        input  cyc_o, stb_o, we_o, sel_o, adr_o, dat_o,
        output ack_i, err_i, dat_i
    );

endinterface

// File: rtl/any1_lanesel.sv
// any1_lanesel -- byte-lane mask generator.
//
// Produces the 16-bit lane mask for an access of size sz starting at byte
// offset off within an octa. Bits [7:0] select lanes of the first bus
// access, bits [15:8] those of the following octa; any bit set in [15:8]
// means the access straddles an octa boundary.
//
// Ports:
//   sz    in   access size
//   off   in   byte offset within the octa (ea[2:0])
//   lanes out  lane mask, (((1 << bytes) - 1) << off)
module any1_lanesel
    import any1_pkg::*;
(
    input  sz_e         sz,
    input  logic [2:0]  off,
    output logic [15:0] lanes
);

    logic [15:0] mask;

    always_comb begin
        case (sz)
            SZ_BYTE:  mask = 16'h0001;
            SZ_WYDE:  mask = 16'h0003;
            SZ_TETRA: mask = 16'h000F;
            default:  mask = 16'h00FF;
        endcase
        lanes = mask << off;
    end

endmodule

// File: rtl/any1_memreq.sv
// any1_memreq -- memory request sequencer.
//
// Takes one load/store request at a time, issues one bus access (two when
// the data straddles an octa boundary), assembles and extends load data,
// and reports completion with a one-clock done pulse plus a fault code.
//
// Ports:
//   clk, rst   clock; synchronous active-high reset
//   req, rdy   request valid / unit idle (req sampled only while rdy=1)
//   we, sz, sgn, ea, wdat
//              store flag, access size, sign-extend, effective address,
//              right-justified store data
//   done       one-clock completion pulse
//   res        load result, updated with done, held otherwise
//   fault      completion status, valid with done
//   bus        memory bus master side
//
// A load that ends in a fault leaves res unchanged, like a store.
module any1_memreq
    import any1_pkg::*;
#(
    parameter int AWID = 32,
    parameter int TMO  = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req,
    output logic            rdy,
    input  logic            we,
    input  logic [1:0]      sz,
    input  logic            sgn,
    input  logic [AWID-1:0] ea,
    input  logic [63:0]     wdat,
    output logic            done,
    output logic [63:0]     res,
    output logic [1:0]      fault,
    any1_memreq_if.master   bus
);

    localparam int             CW       = $clog2(TMO + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TMO - 1);

    state_e          state_q, state_d;
    logic            rdy_q,   rdy_d;
    logic            cyc_q,   cyc_d;
    logic            stb_q,   stb_d;
    logic            we_o_q,  we_o_d;
    logic [7:0]      sel_q,   sel_d;
    logic [AWID-1:0] adr_q,   adr_d;
    logic [63:0]     dat_q,   dat_d;
    logic            done_q,  done_d;
    logic [63:0]     res_q,   res_d;
    fault_e          fault_q, fault_d;
    logic [CW-1:0]   cnt_q,   cnt_d;

    // Request fields latched at acceptance.
    logic [2:0]      off_q,   off_d;
    sz_e             sz_q,    sz_d;
    logic            wel_q,   wel_d;
    logic            sgn_q,   sgn_d;
    logic [63:0]     wdat_q,  wdat_d;
    logic            split_q, split_d;
    logic [63:0]     ld_q,    ld_d;

    // The single lane-mask generator looks at the live request while idle
    // and at the latched request during the access phases.
    sz_e         ls_sz;
    logic [2:0]  ls_off;
    logic [15:0] lanes;

    assign ls_sz  = (state_q == IDLE) ? sz_e'(sz) : sz_q;
    assign ls_off = (state_q == IDLE) ? ea[2:0]   : off_q;

    any1_lanesel u_lanesel (
        .sz    (ls_sz),
        .off   (ls_off),
        .lanes (lanes)
    );

    // sh1 aligns first-octa lanes down to bit 0; sh2 moves second-octa
    // lanes up past the bytes already taken from the first octa.
    logic [5:0]  sh1;
    logic [6:0]  sh2;
    logic [63:0] ld1;
    logic [63:0] ld2;

    assign sh1 = {off_q, 3'b000};
    assign sh2 = 7'd64 - {1'b0, off_q, 3'b000};
    assign ld1 = bus.dat_i >> sh1;
    assign ld2 = ld_q | (bus.dat_i << sh2);

    // NOTE: every signal assigned here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        stb_d   = stb_q;
        we_o_d  = we_o_q;
        sel_d   = sel_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        done_d  = 1'b0;
        res_d   = res_q;
        fault_d = fault_q;
        cnt_d   = cnt_q;
        off_d   = off_q;
        sz_d    = sz_q;
        wel_d   = wel_q;
        sgn_d   = sgn_q;
        wdat_d  = wdat_q;
        split_d = split_q;
        ld_d    = ld_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    off_d   = ea[2:0];
                    sz_d    = sz_e'(sz);
                    wel_d   = we;
                    sgn_d   = sgn;
                    wdat_d  = wdat;
                    split_d = |lanes[15:8];
                    ld_d    = '0;
                    adr_d   = {ea[AWID-1:3], 3'b000};
                    sel_d   = lanes[7:0];
                    dat_d   = wdat << {ea[2:0], 3'b000};
                    we_o_d  = we;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ACC1;
                end
            end

            ACC1, ACC2: begin
                if (state_q == ACC2 && !stb_q) begin
                    // Second access starts after one dead clock; address
                    // and data were already set up when ACC1 was acked.
                    cyc_d  = 1'b1;
                    stb_d  = 1'b1;
                    we_o_d = wel_q;
                    sel_d  = lanes[15:8];
                    cnt_d  = '0;
                end else if (bus.err_i || bus.ack_i || cnt_q == CNT_LAST) begin
                    cyc_d  = 1'b0;
                    stb_d  = 1'b0;
                    we_o_d = 1'b0;
                    sel_d  = '0;
                    if (bus.err_i) begin
                        // Error wins over a simultaneous ack and skips ACC2.
                        state_d = FIN;
                        done_d  = 1'b1;
                        fault_d = FLT_BUS;
                    end else if (bus.ack_i && state_q == ACC1 && split_q) begin
                        state_d = ACC2;
                        adr_d   = adr_q + AWID'(8);
                        dat_d   = wdat_q >> sh2;
                        ld_d    = ld1;
                    end else if (bus.ack_i) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                        fault_d = FLT_OK;
                        if (!wel_q) begin
                            res_d = load_ext((state_q == ACC1) ? ld1 : ld2,
                                             sz_q, sgn_q);
                        end
                    end else begin
                        state_d = FIN;
                        done_d  = 1'b1;
                        fault_d = FLT_TMO;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        rdy_d = (state_d == IDLE);
    end

    // NOTE: state flops use non-blocking assignments so every register
    // samples its next value from the same pre-edge snapshot.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rdy_q   <= 1'b1;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_o_q  <= 1'b0;
            sel_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            done_q  <= 1'b0;
            res_q   <= '0;
            fault_q <= FLT_OK;
            cnt_q   <= '0;
            off_q   <= '0;
            sz_q    <= SZ_BYTE;
            wel_q   <= 1'b0;
            sgn_q   <= 1'b0;
            wdat_q  <= '0;
            split_q <= 1'b0;
            ld_q    <= '0;
        end else begin
            state_q <= state_d;
            rdy_q   <= rdy_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            we_o_q  <= we_o_d;
            sel_q   <= sel_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            done_q  <= done_d;
            res_q   <= res_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
            off_q   <= off_d;
            sz_q    <= sz_d;
            wel_q   <= wel_d;
            sgn_q   <= sgn_d;
            wdat_q  <= wdat_d;
            split_q <= split_d;
            ld_q    <= ld_d;
        end
    end

    assign rdy       = rdy_q;
    assign done      = done_q;
    assign res       = res_q;
    assign fault     = fault_q;
    assign bus.cyc_o = cyc_q;
    assign bus.stb_o = stb_q;
    assign bus.we_o  = we_o_q;
    assign bus.sel_o = sel_q;
    assign bus.adr_o = adr_q;
    assign bus.dat_o = dat_q;

endmodule

// File: tb/tb_any1_memreq.sv
// tb_any1_memreq -- self-checking bench for any1_memreq.
//
// A bus-slave task answers each access after a chosen number of wait
// clocks. Expected lanes, addresses, write data and load results are
// derived byte-by-byte from the request (which byte of memory lands in
// which lane of which octa), independent of the shift formulation.
module tb_any1_memreq;

    localparam int TMO = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        rdy;
    logic        we;
    logic [1:0]  sz;
    logic        sgn;
    logic [31:0] ea;
    logic [63:0] wdat;
    logic        done;
    logic [63:0] res;
    logic [1:0]  fault;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] res_model = '0;

    any1_memreq_if #(.AWID(32)) bus ();

    any1_memreq #(.AWID(32), .TMO(TMO)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .rdy   (rdy),
        .we    (we),
        .sz    (sz),
        .sgn   (sgn),
        .ea    (ea),
        .wdat  (wdat),
        .done  (done),
        .res   (res),
        .fault (fault),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Called at the negedge where the strobe should first be high.
    // rsp: 0 = ack, 1 = bus error, 2 = never answer (timeout).
    task automatic bus_phase(input string tag, input logic [31:0] e_adr, input logic [7:0] e_sel,
                             input logic [63:0] e_dat, input logic e_we, input int dly,
                             input int rsp, input logic [63:0] d);
        check({tag, "_cyc"}, 64'(bus.cyc_o), 64'd1);
        check({tag, "_stb"}, 64'(bus.stb_o), 64'd1);
        check({tag, "_adr"}, 64'(bus.adr_o), 64'(e_adr));
        check({tag, "_sel"}, 64'(bus.sel_o), 64'(e_sel));
        check({tag, "_dat"}, bus.dat_o, e_dat);
        check({tag, "_we"},  64'(bus.we_o), 64'(e_we));
        if (rsp == 2) begin
            for (int i = 1; i < TMO; i++) begin
                @(negedge clk);
                check({tag, "_hold"}, 64'(bus.stb_o), 64'd1);
            end
        end else begin
            for (int i = 0; i < dly; i++) begin
                // Requests while busy must be ignored.
                req = 1'b1;
                ea  = $urandom;
                sz  = 2'($urandom_range(0, 3));
                @(negedge clk);
                req = 1'b0;
                check({tag, "_hold"}, 64'(bus.stb_o), 64'd1);
            end
            bus.dat_i = d;
            if (rsp == 1) begin
                bus.err_i = 1'b1;
                bus.ack_i = 1'($urandom_range(0, 1));
            end else begin
                bus.ack_i = 1'b1;
            end
        end
        @(negedge clk);
        bus.ack_i = 1'b0;
        bus.err_i = 1'b0;
        bus.dat_i = {$urandom, $urandom};
        check({tag, "_drop"}, 64'({bus.cyc_o, bus.stb_o}), 64'd0);
    endtask

    // mode: 0 = ok, 1 = error on first access, 2 = error on second access
    // (ok if not split), 3 = timeout on first access.
    task automatic xfer(input string tag, input logic w, input logic [1:0] s, input logic g,
                        input logic [31:0] a, input logic [63:0] wd, input int dly1,
                        input int dly2, input int mode, input logic [63:0] d1,
                        input logic [63:0] d2);
        int          off;
        int          nb;
        bit          split;
        logic [31:0] adr1;
        logic [31:0] adr2;
        logic [7:0]  sel1;
        logic [7:0]  sel2;
        logic [63:0] dat1;
        logic [63:0] dat2;
        logic [63:0] v;
        logic [1:0]  e_fault;
        int          rsp1;

        off   = int'(a[2:0]);
        nb    = 1 << s;
        split = (off + nb) > 8;
        adr1  = {a[31:3], 3'b000};
        adr2  = adr1 + 32'd8;
        dat1  = '0;
        dat2  = '0;
        for (int l = 0; l < 8; l++) begin
            sel1[l] = (l >= off) && (l < off + nb);
            sel2[l] = (l + 8) < (off + nb);
            if (l >= off)         dat1[8*l +: 8] = wd[8*(l-off) +: 8];
            if (l + 8 - off < 8)  dat2[8*l +: 8] = wd[8*(l+8-off) +: 8];
        end

        @(negedge clk);
        check({tag, "_rdy"}, 64'(rdy), 64'd1);
        req = 1'b1; we = w; sz = s; sgn = g; ea = a; wdat = wd;
        @(negedge clk);
        req = 1'b0;
        check({tag, "_busy"}, 64'(rdy), 64'd0);

        rsp1 = (mode == 1) ? 1 : (mode == 3) ? 2 : 0;
        bus_phase({tag, "_p1"}, adr1, sel1, dat1, w, dly1, rsp1, d1);
        if (split && (mode == 0 || mode == 2)) begin
            check({tag, "_dead"}, 64'({done, bus.stb_o}), 64'd0);
            @(negedge clk);
            bus_phase({tag, "_p2"}, adr2, sel2, dat2, w, dly2, (mode == 2) ? 1 : 0, d2);
        end

        if (mode == 1 || (mode == 2 && split)) e_fault = 2'd1;
        else if (mode == 3)                    e_fault = 2'd2;
        else                                   e_fault = 2'd0;

        if (e_fault == 2'd0 && !w) begin
            v = '0;
            for (int i = 0; i < nb; i++) begin
                if (off + i < 8) v[8*i +: 8] = d1[8*(off+i) +: 8];
                else             v[8*i +: 8] = d2[8*(off+i-8) +: 8];
            end
            for (int i = nb; i < 8; i++)
                v[8*i +: 8] = (g && v[8*nb-1]) ? 8'hFF : 8'h00;
            res_model = v;
        end

        check({tag, "_done"},  64'(done),  64'd1);
        check({tag, "_fault"}, 64'(fault), 64'(e_fault));
        check({tag, "_res"},   res,        res_model);
        @(negedge clk);
        check({tag, "_pulse"}, 64'(done), 64'd0);
        check({tag, "_idle"},  64'({rdy, bus.stb_o}), 64'b10);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; sz = 2'd0; sgn = 1'b0; ea = '0; wdat = '0;
        bus.ack_i = 1'b0; bus.err_i = 1'b0; bus.dat_i = '0;
        repeat (2) @(negedge clk);
        check("rst_rdy",  64'(rdy), 64'd1);
        check("rst_bus",  64'({bus.cyc_o, bus.stb_o, bus.we_o, bus.sel_o}), 64'd0);
        check("rst_adr",  64'(bus.adr_o), 64'd0);
        check("rst_dat",  bus.dat_o, 64'd0);
        check("rst_out",  64'({done, fault}), 64'd0);
        check("rst_res",  res, 64'd0);
        rst = 1'b0;

        // Aligned octa load, ack after one wait clock.
        xfer("octa_ld", 1'b0, 2'd3, 1'b0, 32'h1000, 64'd0, 1, 0, 0,
             64'h0123456789ABCDEF, 64'd0);
        check("octa_ld_val", res, 64'h0123456789ABCDEF);
        // Signed byte load from lane 3.
        xfer("byte_ld", 1'b0, 2'd0, 1'b1, 32'h1003, 64'd0, 0, 0, 0,
             64'h0000_0000_8000_0000, 64'd0);
        check("byte_ld_val", res, 64'hFFFF_FFFF_FFFF_FF80);
        // Split tetra store: the store must leave res alone.
        xfer("split_st", 1'b1, 2'd2, 1'b0, 32'h1006, 64'hAABBCCDD, 0, 2, 0,
             64'd0, 64'd0);
        check("split_st_res", res, 64'hFFFF_FFFF_FFFF_FF80);
        // Split signed load wrapping the address space.
        xfer("wrap_ld", 1'b0, 2'd2, 1'b1, 32'hFFFF_FFFE, 64'd0, 1, 1, 0,
             64'h9988_7766_5544_3322, 64'h0F0E_0D0C_0B0A_0908);
        // Bus error on the first access of a split.
        xfer("err_split", 1'b0, 2'd3, 1'b0, 32'h2005, 64'd0, 1, 0, 1,
             {$urandom, $urandom}, 64'd0);
        check("err_no_acc2", 64'(bus.cyc_o), 64'd0);
        // Timeout on an unanswered access.
        xfer("timeout", 1'b0, 2'd1, 1'b0, 32'h3002, 64'd0, 0, 0, 3, 64'd0, 64'd0);

        // Reset in the middle of an access.
        @(negedge clk);
        req = 1'b1; we = 1'b0; sz = 2'd3; ea = 32'h4000;
        @(negedge clk);
        req = 1'b0;
        check("rstmid_cyc_on", 64'(bus.cyc_o), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        res_model = '0;
        check("rstmid_cyc_off", 64'({bus.cyc_o, bus.stb_o}), 64'd0);
        check("rstmid_res", res, 64'd0);
        for (int i = 0; i < 3; i++) begin
            check("rstmid_nodone", 64'(done), 64'd0);
            @(negedge clk);
        end
        check("rstmid_rdy", 64'(rdy), 64'd1);

        for (int n = 0; n < 150; n++) begin
            int          r;
            int          mode;
            r    = $urandom_range(0, 19);
            mode = (r == 0) ? 1 : (r == 1) ? 2 : (r == 2) ? 3 : 0;
            xfer("rnd", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), $urandom, {$urandom, $urandom},
                 $urandom_range(0, 3), $urandom_range(0, 3), mode,
                 {$urandom, $urandom}, {$urandom, $urandom});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
